// File: rtl/iic_seq_pkg.sv
// Shared encodings for the IIC transfer sequencer: FSM states, call-bit indices
// and the width helper for the done-timeout counter.
package iic_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_TAG,
        WR_CALL,
        RD_TAG,
        RD_CALL,
        FIN
    } seq_state_t;

    localparam int unsigned CALL_WR = 1;
    localparam int unsigned CALL_RD = 0;

    // Counter only has to reach TMO-1, so clog2(TMO) bits are enough.
    function automatic int unsigned tmo_width(input int unsigned tmo);
        return (tmo > 1) ? $clog2(tmo) : 1;
    endfunction

endpackage

// File: rtl/iic_seq_tmo.sv
// Done-timeout counter for the sequencer: cleared outside the call states,
// counts while enabled and flags the TMO-th waiting cycle.
module iic_seq_tmo
    import iic_seq_pkg::*;
#(
    parameter int unsigned TMO = 1000000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = tmo_width(TMO);

    logic [W-1:0] cnt;

    assign expired = en && (cnt == W'(TMO - 1));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/iic_seq_ctrl.sv
// IIC transfer sequencer: writes NBYTE bytes to base..base+NBYTE-1, then reads them back.
// Optional read-back verification and mismatch counter under `IIC_SEQ_VERIFY_EN.
module iic_seq_ctrl
    import iic_seq_pkg::*;
#(
    parameter int unsigned NBYTE = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned TMO   = 1000000
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                iStart,
    input  logic                iRdOnly,
    input  logic [AW-1:0]       iBase,
    input  logic [NBYTE*DW-1:0] iWrData,
    output logic [NBYTE*DW-1:0] oRdData,
    output logic                oBusy,
    output logic                oDone,
    output logic                oErr,
    output logic [1:0]          oCall,
    input  logic [1:0]          iDone,
    input  logic [1:0]          iTag,
    output logic [AW-1:0]       oAddr,
    output logic [DW-1:0]       oData,
    input  logic [DW-1:0]       iData
`ifdef IIC_SEQ_VERIFY_EN
    ,
    output logic [4:0]          oMisCnt
`endif
);

    localparam int unsigned KW = (NBYTE > 1) ? $clog2(NBYTE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NBYTE - 1);

    seq_state_t         state;
    logic [KW-1:0]      k;
    logic [AW-1:0]      base;
    logic [NBYTE*DW-1:0] wdat;
    logic [DW-1:0]      wbyte;
    logic               in_call;
    logic               tmo_exp;

`ifdef IIC_SEQ_VERIFY_EN
    logic               rdonly;
    logic               mis_any;
`endif

    // Byte k of the latched write word; byte 0 is the most significant.
    always_comb begin
        wbyte = '0;
        for (int unsigned i = 0; i < NBYTE; i++) begin
            if (k == KW'(i)) begin
                wbyte = wdat[(NBYTE-i)*DW-1 -: DW];
            end
        end
    end

    assign in_call = (state == WR_CALL) || (state == RD_CALL);

    iic_seq_tmo #(
        .TMO(TMO)
    ) u_tmo (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .clr    (!in_call),
        .en     (in_call),
        .expired(tmo_exp)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            k       <= '0;
            base    <= '0;
            wdat    <= '0;
            oRdData <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
            oCall   <= '0;
            oAddr   <= '0;
            oData   <= '0;
`ifdef IIC_SEQ_VERIFY_EN
            rdonly  <= 1'b0;
            mis_any <= 1'b0;
            oMisCnt <= '0;
`endif
        end else begin
            oDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        base  <= iBase;
                        wdat  <= iWrData;
                        oErr  <= 1'b0;
                        k     <= '0;
                        oBusy <= 1'b1;
                        state <= iRdOnly ? RD_TAG : WR_TAG;
`ifdef IIC_SEQ_VERIFY_EN
                        rdonly  <= iRdOnly;
                        mis_any <= 1'b0;
                        oMisCnt <= '0;
`endif
                    end
                end
                // Call outputs are set on the TAG->CALL transition so they are
                // valid for the whole CALL state and low for the TAG cycle.
                WR_TAG: begin
                    if (!iTag[CALL_WR]) begin
                        oCall[CALL_WR] <= 1'b1;
                        oAddr          <= base + AW'(k);
                        oData          <= wbyte;
                        state          <= WR_CALL;
                    end
                end
                WR_CALL: begin
                    if (iDone[CALL_WR]) begin
                        oCall[CALL_WR] <= 1'b0;
                        if (k == KLAST) begin
                            k     <= '0;
                            state <= RD_TAG;
                        end else begin
                            k     <= k + 1'b1;
                            state <= WR_TAG;
                        end
                    end else if (tmo_exp) begin
                        oCall <= '0;
                        oErr  <= 1'b1;
                        state <= FIN;
                    end
                end
                RD_TAG: begin
                    if (!iTag[CALL_RD]) begin
                        oCall[CALL_RD] <= 1'b1;
                        oAddr          <= base + AW'(k);
                        state          <= RD_CALL;
                    end
                end
                RD_CALL: begin
                    if (iDone[CALL_RD]) begin
                        oCall[CALL_RD] <= 1'b0;
                        for (int unsigned i = 0; i < NBYTE; i++) begin
                            if (k == KW'(i)) begin
                                oRdData[(NBYTE-i)*DW-1 -: DW] <= iData;
                            end
                        end
`ifdef IIC_SEQ_VERIFY_EN
                        if (!rdonly && (iData != wbyte)) begin
                            mis_any <= 1'b1;
                            if (oMisCnt != 5'd31) begin
                                oMisCnt <= oMisCnt + 1'b1;
                            end
                        end
`endif
                        if (k == KLAST) begin
                            k     <= '0;
                            state <= FIN;
                        end else begin
                            k     <= k + 1'b1;
                            state <= RD_TAG;
                        end
                    end else if (tmo_exp) begin
                        oCall <= '0;
                        oErr  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                    k     <= '0;
                    state <= IDLE;
`ifdef IIC_SEQ_VERIFY_EN
                    if (mis_any) begin
                        oErr <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_seq_ctrl.sv
// Directed bench for iic_seq_ctrl (NBYTE=3, TMO=100) with a behavioural echo-memory slave.
// Build with +define+IIC_SEQ_VERIFY_EN to include the read-back verification scenario.
module tb_iic_seq_ctrl;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        iStart, iRdOnly;
    logic [7:0]  iBase;
    logic [23:0] iWrData;
    logic [23:0] oRdData;
    logic        oBusy, oDone, oErr;
    logic [1:0]  oCall;
    logic [1:0]  iDone;
    logic [1:0]  iTag;
    logic [7:0]  oAddr, oData;
    logic [7:0]  iData;
`ifdef IIC_SEQ_VERIFY_EN
    logic [4:0]  oMisCnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 CLOCK = ~CLOCK;

    iic_seq_ctrl #(
        .NBYTE(3),
        .DW   (8),
        .AW   (8),
        .TMO  (100)
    ) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iStart (iStart),
        .iRdOnly(iRdOnly),
        .iBase  (iBase),
        .iWrData(iWrData),
        .oRdData(oRdData),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oErr   (oErr),
        .oCall  (oCall),
        .iDone  (iDone),
        .iTag   (iTag),
        .oAddr  (oAddr),
        .oData  (oData),
        .iData  (iData)
`ifdef IIC_SEQ_VERIFY_EN
        ,
        .oMisCnt(oMisCnt)
`endif
    );

    // Slave configuration, written only by the stimulus process.
    int          tag_hold     = 0;
    int          hang_addr    = -1;
    int          corrupt_addr = -1;
    logic [7:0]  pre_base     = 8'h00;
    logic [23:0] pre_val      = 24'h0;
    logic        pre_go       = 1'b0;

    // Slave state, written only by the slave process.
    logic [7:0]  mem [0:255];
    logic        pre_seen = 1'b0;
    logic        s_busy   = 1'b0;
    int          lat_cnt  = 0;
    int          tag_cnt  = 0;

    // Echo-memory slave: acknowledges each call on its third cycle, optionally
    // holding the write tag busy, hanging one read address or corrupting one.
    always @(negedge CLOCK) begin
        if (pre_go != pre_seen) begin
            mem[pre_base]        = pre_val[23:16];
            mem[pre_base + 8'd1] = pre_val[15:8];
            mem[pre_base + 8'd2] = pre_val[7:0];
            pre_seen = pre_go;
        end
        iDone   = 2'b00;
        iTag[0] = 1'b0;
        if (tag_cnt > 0) begin
            iTag[1] = 1'b1;
            tag_cnt--;
        end else begin
            iTag[1] = 1'b0;
        end
        if (oBusy && !s_busy && tag_hold > 0) begin
            tag_cnt = tag_hold;
            iTag[1] = 1'b1;
        end
        s_busy = oBusy;
        if (!RESET) begin
            lat_cnt = 0;
        end else if (oCall[1]) begin
            if (lat_cnt == 2) begin
                mem[oAddr] = oData;
                iDone[1]   = 1'b1;
                lat_cnt    = 0;
                if (tag_hold > 0) begin
                    tag_cnt = tag_hold;
                    iTag[1] = 1'b1;
                end
            end else begin
                lat_cnt++;
            end
        end else if (oCall[0]) begin
            if (int'(oAddr) == hang_addr) begin
                lat_cnt = 0;
            end else if (lat_cnt == 2) begin
                iData    = (int'(oAddr) == corrupt_addr) ? 8'h00 : mem[oAddr];
                iDone[0] = 1'b1;
                lat_cnt  = 0;
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // Bus monitor, restarts its counters on each rising oBusy.
    logic [7:0] wr_addr_log [0:15];
    logic [7:0] wr_data_log [0:15];
    logic [7:0] rd_addr_log [0:15];
    int   wr_n, rd_n, wr_cyc, rd_cyc, done_n, both_n, tag_viol;
    logic m_busy = 1'b0;
    logic [1:0] m_call = 2'b00;

    always @(posedge CLOCK) begin
        #1;
        if (!RESET) begin
            m_busy = 1'b0;
        end else begin
            if (oBusy && !m_busy) begin
                wr_n = 0; rd_n = 0; wr_cyc = 0; rd_cyc = 0;
                done_n = 0; both_n = 0; tag_viol = 0;
            end
            m_busy = oBusy;
            if (oCall == 2'b11) both_n++;
            if (oCall[1] && !m_call[1]) begin
                if (wr_n < 16) begin
                    wr_addr_log[wr_n] = oAddr;
                    wr_data_log[wr_n] = oData;
                end
                wr_n++;
                if (iTag[1]) tag_viol++;
            end
            if (oCall[0] && !m_call[0]) begin
                if (rd_n < 16) rd_addr_log[rd_n] = oAddr;
                rd_n++;
            end
            if (oCall[1]) wr_cyc++;
            if (oCall[0]) rd_cyc++;
            if (oDone) done_n++;
        end
        m_call = RESET ? oCall : 2'b00;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic preload(input logic [7:0] base, input logic [23:0] val);
        pre_base = base;
        pre_val  = val;
        pre_go   = ~pre_go;
        repeat (2) @(negedge CLOCK);
    endtask

    task automatic run_seq(input logic [7:0] base, input logic [23:0] wd, input logic rdo,
                           input int poke, input string name, output int cyc);
        @(negedge CLOCK);
        iBase = base; iWrData = wd; iRdOnly = rdo; iStart = 1'b1;
        @(negedge CLOCK);
        iStart = 1'b0;
        cyc = 0;
        while (oDone !== 1'b1 && cyc < 3000) begin
            @(negedge CLOCK);
            cyc++;
            if (poke > 0 && cyc == poke) begin
                iStart = 1'b1; iBase = 8'h77; iWrData = '0; iRdOnly = 1'b1;
            end else begin
                iStart = 1'b0;
            end
        end
        iStart = 1'b0;
        compared++;
        if (oDone !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_done: no oDone after %0d cycles, required within 3000", name, cyc);
        end
        repeat (3) @(negedge CLOCK);
    endtask

    task automatic test_reset;
        #1 RESET = 1'b0;
        #2;
        compared++;
        if ({oCall, oBusy, oDone, oErr, oAddr, oData} !== 21'h0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got call=%b busy=%b done=%b err=%b addr=%h data=%h, required all 0",
                     oCall, oBusy, oDone, oErr, oAddr, oData);
        end
        compared++;
        if (oRdData !== 24'h0) begin
            mismatched++;
            $display("FAIL reset_rddata: got %h, required 000000", oRdData);
        end
`ifdef IIC_SEQ_VERIFY_EN
        compared++;
        if (oMisCnt !== 5'd0) begin
            mismatched++;
            $display("FAIL reset_miscnt: got %0d, required 0", oMisCnt);
        end
`endif
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    task automatic test_basic;
        int cyc;
        run_seq(8'h10, 24'hABCDEF, 1'b0, 0, "basic", cyc);
        compared++;
        if (wr_n !== 3 || {wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]} !== 24'h101112) begin
            mismatched++;
            $display("FAIL basic_wr_addr: got n=%0d %h %h %h, required 3 writes 10 11 12",
                     wr_n, wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]);
        end
        compared++;
        if ({wr_data_log[0], wr_data_log[1], wr_data_log[2]} !== 24'hABCDEF) begin
            mismatched++;
            $display("FAIL basic_wr_data: got %h %h %h, required AB CD EF",
                     wr_data_log[0], wr_data_log[1], wr_data_log[2]);
        end
        compared++;
        if (oRdData !== 24'hABCDEF) begin
            mismatched++;
            $display("FAIL basic_rddata: got %h, required ABCDEF", oRdData);
        end
        compared++;
        if (done_n !== 1 || oErr !== 1'b0 || oBusy !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_status: got done_pulses=%0d err=%b busy=%b, required 1 0 0",
                     done_n, oErr, oBusy);
        end
        compared++;
        if (both_n !== 0 || rd_n !== 3) begin
            mismatched++;
            $display("FAIL basic_calls: got both_high=%0d reads=%0d, required 0 and 3", both_n, rd_n);
        end
    endtask

    task automatic test_tag_wait;
        int cyc;
        tag_hold = 50;
        run_seq(8'h30, 24'h5A6B7C, 1'b0, 20, "tag", cyc);
        tag_hold = 0;
        compared++;
        if (tag_viol !== 0) begin
            mismatched++;
            $display("FAIL tag_respect: got %0d write calls under busy tag, required 0", tag_viol);
        end
        compared++;
        if (wr_n !== 3 || {wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]} !== 24'h303132) begin
            mismatched++;
            $display("FAIL tag_order: got n=%0d %h %h %h, required 3 writes 30 31 32",
                     wr_n, wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]);
        end
        compared++;
        if (cyc < 150) begin
            mismatched++;
            $display("FAIL tag_duration: got %0d cycles, required at least 150", cyc);
        end
        compared++;
        if (oRdData !== 24'h5A6B7C || done_n !== 1) begin
            mismatched++;
            $display("FAIL tag_busy_start: got rd=%h done_pulses=%0d, required 5A6B7C and 1",
                     oRdData, done_n);
        end
    endtask

    task automatic test_rd_only;
        int cyc;
        preload(8'h20, 24'h112233);
        run_seq(8'h20, 24'hFFFFFF, 1'b1, 0, "rdonly", cyc);
        compared++;
        if (wr_n !== 0 || wr_cyc !== 0) begin
            mismatched++;
            $display("FAIL rdonly_nowrite: got %0d write calls, %0d cycles, required 0", wr_n, wr_cyc);
        end
        compared++;
        if (oRdData !== 24'h112233 || oErr !== 1'b0) begin
            mismatched++;
            $display("FAIL rdonly_data: got rd=%h err=%b, required 112233 and 0", oRdData, oErr);
        end
        compared++;
        if ({rd_addr_log[0], rd_addr_log[1], rd_addr_log[2]} !== 24'h202122) begin
            mismatched++;
            $display("FAIL rdonly_addr: got %h %h %h, required 20 21 22",
                     rd_addr_log[0], rd_addr_log[1], rd_addr_log[2]);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        hang_addr = 8'h41;
        run_seq(8'h40, 24'h445566, 1'b0, 0, "timeout", cyc);
        hang_addr = -1;
        compared++;
        if (rd_cyc !== 103 || wr_cyc !== 9) begin
            mismatched++;
            $display("FAIL timeout_call_len: got rd_cycles=%0d wr_cycles=%0d, required 103 and 9",
                     rd_cyc, wr_cyc);
        end
        compared++;
        if (oErr !== 1'b1 || done_n !== 1 || oCall !== 2'b00) begin
            mismatched++;
            $display("FAIL timeout_status: got err=%b done_pulses=%0d call=%b, required 1 1 00",
                     oErr, done_n, oCall);
        end
        compared++;
        if (oRdData !== 24'h442233) begin
            mismatched++;
            $display("FAIL timeout_rddata: got %h, required 442233", oRdData);
        end
    endtask

    task automatic test_addr_wrap;
        int cyc;
        run_seq(8'hFF, 24'h9C8D7E, 1'b0, 0, "wrap", cyc);
        compared++;
        if ({wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]} !== 24'hFF0001 ||
            {rd_addr_log[0], rd_addr_log[1], rd_addr_log[2]} !== 24'hFF0001) begin
            mismatched++;
            $display("FAIL wrap_addr: got wr %h %h %h rd %h %h %h, required FF 00 01",
                     wr_addr_log[0], wr_addr_log[1], wr_addr_log[2],
                     rd_addr_log[0], rd_addr_log[1], rd_addr_log[2]);
        end
        compared++;
        if (oRdData !== 24'h9C8D7E || oErr !== 1'b0) begin
            mismatched++;
            $display("FAIL wrap_data: got rd=%h err=%b, required 9C8D7E and 0 (err cleared by start)",
                     oRdData, oErr);
        end
    endtask

`ifdef IIC_SEQ_VERIFY_EN
    task automatic test_verify;
        int cyc;
        corrupt_addr = 8'h72;
        run_seq(8'h70, 24'hABCDEF, 1'b0, 0, "verify", cyc);
        corrupt_addr = -1;
        compared++;
        if (oErr !== 1'b1 || oMisCnt !== 5'd1) begin
            mismatched++;
            $display("FAIL verify_err: got err=%b miscnt=%0d, required 1 and 1", oErr, oMisCnt);
        end
        compared++;
        if (oRdData !== 24'hABCD00) begin
            mismatched++;
            $display("FAIL verify_rddata: got %h, required ABCD00", oRdData);
        end
    endtask
`endif

    task automatic test_reset_mid_seq;
        int cyc;
        int w;
        @(negedge CLOCK);
        iBase = 8'h50; iWrData = 24'h010203; iRdOnly = 1'b0; iStart = 1'b1;
        @(negedge CLOCK);
        iStart = 1'b0;
        w = 0;
        while (!(oCall[1] === 1'b1 && oAddr === 8'h51) && w < 200) begin
            @(negedge CLOCK);
            w++;
        end
        compared++;
        if (!(oCall[1] === 1'b1 && oAddr === 8'h51)) begin
            mismatched++;
            $display("FAIL midrst_reach: write call to 51 not seen in %0d cycles, required within 200", w);
        end
        #2 RESET = 1'b0;
        #1;
        compared++;
        if ({oCall, oBusy, oDone, oErr, oAddr, oData} !== 21'h0) begin
            mismatched++;
            $display("FAIL midrst_ctrl: got call=%b busy=%b done=%b err=%b addr=%h data=%h, required all 0",
                     oCall, oBusy, oDone, oErr, oAddr, oData);
        end
        compared++;
        if (oRdData !== 24'h0) begin
            mismatched++;
            $display("FAIL midrst_rddata: got %h, required 000000", oRdData);
        end
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        run_seq(8'h60, 24'h0A0B0C, 1'b0, 0, "midrst_fresh", cyc);
        compared++;
        if (oRdData !== 24'h0A0B0C || oErr !== 1'b0 || done_n !== 1) begin
            mismatched++;
            $display("FAIL midrst_fresh: got rd=%h err=%b done_pulses=%0d, required 0A0B0C 0 1",
                     oRdData, oErr, done_n);
        end
    endtask

    initial begin
        iStart = 1'b0; iRdOnly = 1'b0; iBase = 8'h00; iWrData = 24'h0;
        test_reset;
        test_basic;
        test_tag_wait;
        test_rd_only;
        test_timeout;
        test_addr_wrap;
`ifdef IIC_SEQ_VERIFY_EN
        test_verify;
`endif
        test_reset_mid_seq;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
